psk_symbol_modulator: RTL

//   Parametrised successor to the single-bit BPSK transmitter: buffers input symbols, times them at a programmable

---
 rtl/psk_symbol_modulator_pkg.sv | 64 ++++++
 rtl/psk_symbol_modulator_if.sv | 9 +
 rtl/psk_symbol_modulator_fifo.sv | 55 +++++
 rtl/psk_symbol_modulator.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/psk_symbol_modulator_pkg.sv
// Shared types and symbol-phase tables for the PSK symbol modulator.
// Offsets and deltas are held in eighths of a turn and widened to PHASE_W in the top.
package psk_mod_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    MODE_BPSK = 1'b0,
    MODE_QPSK = 1'b1
  } mode_e;

  localparam int OFS_W = 3;

  localparam logic [OFS_W-1:0] BPSK_OFS_0   = 3'd0;
  localparam logic [OFS_W-1:0] BPSK_OFS_1   = 3'd4;
  localparam logic [OFS_W-1:0] QPSK_OFS_00  = 3'd1;
  localparam logic [OFS_W-1:0] QPSK_OFS_01  = 3'd3;
  localparam logic [OFS_W-1:0] QPSK_OFS_11  = 3'd5;
  localparam logic [OFS_W-1:0] QPSK_OFS_10  = 3'd7;
  localparam logic [OFS_W-1:0] QPSK_DEL_00  = 3'd0;
  localparam logic [OFS_W-1:0] QPSK_DEL_01  = 3'd2;
  localparam logic [OFS_W-1:0] QPSK_DEL_11  = 3'd4;
  localparam logic [OFS_W-1:0] QPSK_DEL_10  = 3'd6;

  localparam int SPS_MIN = 2;

  function automatic logic [OFS_W-1:0] abs_offset(input mode_e mode, input logic [1:0] bits);
    logic [OFS_W-1:0] r;
    r = 3'd0;
    if (mode == MODE_BPSK) begin
      r = bits[0] ? BPSK_OFS_1 : BPSK_OFS_0;
    end else begin
      case (bits)
        2'b00:   r = QPSK_OFS_00;
        2'b01:   r = QPSK_OFS_01;
        2'b11:   r = QPSK_OFS_11;
        2'b10:   r = QPSK_OFS_10;
        default: r = 3'd0;
      endcase
    end
    return r;
  endfunction

  function automatic logic [OFS_W-1:0] diff_delta(input mode_e mode, input logic [1:0] bits);
    logic [OFS_W-1:0] r;
    r = 3'd0;
    if (mode == MODE_BPSK) begin
      r = bits[0] ? BPSK_OFS_1 : BPSK_OFS_0;
    end else begin
      case (bits)
        2'b00:   r = QPSK_DEL_00;
        2'b01:   r = QPSK_DEL_01;
        2'b11:   r = QPSK_DEL_11;
        2'b10:   r = QPSK_DEL_10;
        default: r = 3'd0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/psk_symbol_modulator_if.sv
// Symbol stream handshake between the framing/data source (master) and the modulator (slave).
interface psk_symbol_modulator_if;
  logic [1:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/psk_symbol_modulator_fifo.sv
// psk_sym_fifo: DEPTH x 2-bit symbol FIFO with full/empty/count; pushes on full and pops on empty are dropped.
module psk_sym_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [1:0]               wdata,
  output logic [1:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [1:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 2'b00;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/psk_symbol_modulator.sv
// PSK symbol modulator: buffers symbols, times them at sps samples/symbol and emits carrier+symbol phase for the CORDIC.
// Build option DIFF_ENC_EN selects differential symbol encoding instead of the absolute Gray mapping.
module psk_symbol_modulator
  import psk_mod_pkg::*;
#(
  parameter int PHASE_W    = 32,
  parameter int SPS_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode_qpsk,
  input  logic [PHASE_W-1:0]   phase_step,
  input  logic [SPS_W-1:0]     sps,
  psk_symbol_modulator_if.slave sym,
  output logic [PHASE_W-1:0]   phase_out,
  output logic                 out_en,
  output logic                 sym_strobe,
  output logic                 underrun
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e               state_r;
  logic [SPS_W-1:0]     cnt_r;
  logic [SPS_W-1:0]     sps_l_r;
  logic [SPS_W-1:0]     sps_eff_s;
  logic [PHASE_W-1:0]   acc_r;
  // With DIFF_ENC_EN this is the running differential phase; otherwise the current absolute offset.
  logic [OFS_W-1:0]     ofs_r;
  logic [OFS_W-1:0]     next_ofs_s;
  logic                 boundary_s;
  logic                 pop_s;
  logic [1:0]           fifo_rdata_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [CNT_W-1:0]     fifo_count_unused_s;

  psk_sym_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (sym.s_valid),
    .pop   (pop_s),
    .wdata (sym.s_data),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_unused_s)
  );

  assign sym.s_ready = !fifo_full_s;
  assign boundary_s  = (cnt_r == sps_l_r - SPS_W'(1));

  // Symbol length and phase for the symbol at the FIFO head.
  always_comb begin
    sps_eff_s  = sps;
    next_ofs_s = '0;
    if (sps < SPS_W'(SPS_MIN)) begin
      sps_eff_s = SPS_W'(SPS_MIN);
    end else begin
      sps_eff_s = sps;
    end
`ifdef DIFF_ENC_EN
    next_ofs_s = ofs_r + diff_delta(mode_e'(mode_qpsk), fifo_rdata_s);
`else
    next_ofs_s = abs_offset(mode_e'(mode_qpsk), fifo_rdata_s);
`endif
  end

  // Pop decision: leaving IDLE or reaching a symbol boundary with data waiting.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (en && !fifo_empty_s) pop_s = 1'b1;
        else                     pop_s = 1'b0;
      end
      ACTIVE: begin
        if (en && boundary_s && !fifo_empty_s) pop_s = 1'b1;
        else                                   pop_s = 1'b0;
      end
      default: pop_s = 1'b0;
    endcase
  end

  // Symbol timing FSM, carrier accumulator and sticky underrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      sps_l_r  <= SPS_W'(SPS_MIN);
      acc_r    <= '0;
      ofs_r    <= '0;
      underrun <= 1'b0;
    end else if (!en) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      acc_r    <= '0;
      ofs_r    <= '0;
      underrun <= 1'b0;
    end else begin
      acc_r <= acc_r + phase_step;
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            state_r <= ACTIVE;
            cnt_r   <= '0;
            sps_l_r <= sps_eff_s;
            ofs_r   <= next_ofs_s;
          end else begin
            state_r <= IDLE;
          end
        end
        ACTIVE: begin
          if (boundary_s) begin
            if (pop_s) begin
              cnt_r   <= '0;
              sps_l_r <= sps_eff_s;
              ofs_r   <= next_ofs_s;
            end else begin
              state_r  <= IDLE;
              cnt_r    <= '0;
              underrun <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + SPS_W'(1);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Output stage: phase, amplitude gate and strobe all describe the same sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_out  <= '0;
      out_en     <= 1'b0;
      sym_strobe <= 1'b0;
    end else begin
      phase_out  <= acc_r + {ofs_r, {(PHASE_W-OFS_W){1'b0}}};
      out_en     <= en && (state_r == ACTIVE);
      sym_strobe <= en && (state_r == ACTIVE) && (cnt_r == '0);
    end
  end
endmodule
